// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-entry registered skid buffer ahead of the ALU with
// capture-time operand forwarding and per-cycle snooping of held entries.
module alu_issue_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [RADDR_W-1:0] in_rs1_addr,
    input  logic [RADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic               in_use_pc,
    input  logic               in_use_imm,
    input  logic [3:0]         in_alu_op,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic               in_rd_we,
    input  logic               fwd_ex_we,
    input  logic [RADDR_W-1:0] fwd_ex_rd,
    input  logic [XLEN-1:0]    fwd_ex_data,
    input  logic               fwd_wb_we,
    input  logic [RADDR_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]    fwd_wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    src_a,
    output logic [XLEN-1:0]    src_b,
    output logic [3:0]         alu_op,
    output logic [RADDR_W-1:0] rd_addr,
    output logic               rd_we
);
    localparam logic [3:0] ALU_ADD = 4'd0;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [RADDR_W-1:0] rs1_addr;
        logic [XLEN-1:0]    rs1_data;
        logic [RADDR_W-1:0] rs2_addr;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic               use_pc;
        logic               use_imm;
        logic [3:0]         alu_op;
        logic [RADDR_W-1:0] rd_addr;
        logic               rd_we;
    } entry_t;

    entry_t head_q, head_d, skid_q, skid_d, in_e, head_s, skid_s;
    logic   head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
    logic   in_fire, out_fire;

    // EX result beats WB result; x0 always reads as zero
    function automatic logic [XLEN-1:0] fwd(input logic [RADDR_W-1:0] a, input logic [XLEN-1:0] d);
        return (a == '0) ? '0 :
               (fwd_ex_we && fwd_ex_rd == a) ? fwd_ex_data :
               (fwd_wb_we && fwd_wb_rd == a) ? fwd_wb_data : d;
    endfunction

    assign in_ready  = !skid_valid_q;
    assign out_valid = head_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = head_valid_q && out_ready;

    always_comb begin
        in_e          = '{in_pc, in_rs1_addr, in_rs1_data, in_rs2_addr, in_rs2_data, in_imm,
                          in_use_pc, in_use_imm, in_alu_op, in_rd_addr, in_rd_we};
        in_e.rs1_data = fwd(in_rs1_addr, in_rs1_data);
        in_e.rs2_data = fwd(in_rs2_addr, in_rs2_data);
        head_s          = head_q;
        head_s.rs1_data = fwd(head_q.rs1_addr, head_q.rs1_data);
        head_s.rs2_data = fwd(head_q.rs2_addr, head_q.rs2_data);
        skid_s          = skid_q;
        skid_s.rs1_data = fwd(skid_q.rs1_addr, skid_q.rs1_data);
        skid_s.rs2_data = fwd(skid_q.rs2_addr, skid_q.rs2_data);
        head_d       = head_s;
        skid_d       = skid_s;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (out_fire && skid_valid_q) begin
            head_d       = skid_s;
            skid_valid_d = 1'b0;
        end else if (out_fire) begin
            head_d       = in_fire ? in_e : head_s;
            head_valid_d = in_fire;
        end else if (in_fire && !head_valid_q) begin
            head_d       = in_e;
            head_valid_d = 1'b1;
        end else if (in_fire) begin
            skid_d       = in_e;
            skid_valid_d = 1'b1;
        end
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Outputs reflect this cycle's snooped head so the ALU never sees stale operands
    assign src_a   = head_valid_q ? (head_s.use_pc ? head_s.pc : head_s.rs1_data) : '0;
    assign src_b   = head_valid_q ? (head_s.use_imm ? head_s.imm : head_s.rs2_data) : '0;
    assign alu_op  = head_valid_q ? head_s.alu_op : ALU_ADD;
    assign rd_addr = head_valid_q ? head_s.rd_addr : '0;
    assign rd_we   = head_valid_q && head_s.rd_we;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench; expected ALU inputs are queued at issue
// and compared whenever the stage hands an instruction to the ALU.
module tb_alu_issue_stage;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
    logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
    logic        in_use_pc = 1'b0, in_use_imm = 1'b0, in_rd_we = 1'b0;
    logic [3:0]  in_alu_op = '0;
    logic        fwd_ex_we = 1'b0, fwd_wb_we = 1'b0;
    logic [4:0]  fwd_ex_rd = '0, fwd_wb_rd = '0;
    logic [31:0] fwd_ex_data = '0, fwd_wb_data = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] src_a, src_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd_addr;
    logic        rd_we;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0, errors = 0, stalls = 0;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_use_pc(in_use_pc), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
        .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .src_a(src_a), .src_b(src_b), .alu_op(alu_op),
        .rd_addr(rd_addr), .rd_we(rd_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                        input logic up, input logic ui, input logic [3:0] op,
                        input logic [4:0] rd, input logic we);
        in_pc = pc; in_rs1_addr = r1; in_rs1_data = d1; in_rs2_addr = r2; in_rs2_data = d2;
        in_imm = imm; in_use_pc = up; in_use_imm = ui; in_alu_op = op; in_rd_addr = rd; in_rd_we = we;
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                        input logic up, input logic ui, input logic [3:0] op,
                        input logic [4:0] rd, input logic we,
                        input logic [31:0] ea, input logic [31:0] eb);
        load(pc, r1, d1, r2, d2, imm, up, ui, op, rd, we);
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !in_ready; n++) begin
            stalls++;
            tick();
        end
        if (!in_ready) check("send_ready", {31'd0, in_ready}, 32'd1);
        else exp_q.push_back('{ea, eb, op, rd, we});
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", src_a, 32'hDEAD_DEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("src_a", src_a, e.a);
                check("src_b", src_b, e.b);
                check("alu_op", {28'd0, alu_op}, {28'd0, e.op});
                check("rd_addr", {27'd0, rd_addr}, {27'd0, e.rd});
                check("rd_we", {31'd0, rd_we}, {31'd0, e.we});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b1;
        repeat (3) tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_src_a", src_a, 32'd0);
        check("rst_src_b", src_b, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
        check("rst_rd", {26'd0, rd_we, rd_addr}, 32'd0);

        // single issue, 1-cycle latency
        out_ready = 1'b1;
        send(32'h0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd3, 1'b1, 32'd5, 32'd7);
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_src_a", src_a, 32'd5);
        check("lat_in_ready", {31'd0, in_ready}, 32'd1);

        // capture forwarding priority and x0
        fwd_ex_we = 1'b1; fwd_ex_rd = 5'd3; fwd_ex_data = 32'h10;
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'h20;
        send(32'h0, 5'd3, 32'd1, 5'd0, 32'h55, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd4, 1'b1, 32'h10, 32'd0);
        fwd_ex_we = 1'b0; fwd_wb_rd = 5'd5;
        send(32'h0, 5'd5, 32'd1, 5'd6, 32'h66, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd4, 1'b1, 32'h20, 32'h66);
        fwd_wb_we = 1'b0;
        fwd_ex_we = 1'b1; fwd_ex_rd = 5'd0; fwd_ex_data = 32'h99;
        send(32'h0, 5'd0, 32'h77, 5'd0, 32'h88, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd0, 1'b0, 32'd0, 32'd0);
        fwd_ex_we = 1'b0;
        tick();

        // backpressure fills the skid entry; order preserved on release
        out_ready = 1'b0;
        send(32'h0, 5'd1, 32'h11, 5'd2, 32'h12, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd8, 1'b1, 32'h11, 32'h12);
        send(32'h0, 5'd1, 32'h21, 5'd2, 32'h22, 32'd0, 1'b0, 1'b0, ALU_SUB, 5'd9, 1'b1, 32'h21, 32'h22);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        load(32'h0, 5'd1, 32'h31, 5'd2, 32'h32, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd10, 1'b1);
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        check("full_hold_src_a", src_a, 32'h11);
        out_ready = 1'b1;
        tick();
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
        check("drain_out_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("drain_empty", {31'd0, out_valid}, 32'd0);

        // snoop updates held head and skid entries and retains the value
        out_ready = 1'b0;
        send(32'h0, 5'd1, 32'h31, 5'd4, 32'd0, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd11, 1'b1, 32'h31, 32'hABCD);
        send(32'h0, 5'd4, 32'd0, 5'd4, 32'd0, 32'h1234, 1'b0, 1'b1, ALU_ADD, 5'd12, 1'b1, 32'hABCD, 32'h1234);
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'hABCD;
        tick();
        fwd_wb_we = 1'b0;
        repeat (2) tick();
        check("snoop_hold_b", src_b, 32'hABCD);
        out_ready = 1'b1;
        repeat (3) tick();

        // flush with both entries full, then with an accepted incoming instruction
        out_ready = 1'b0;
        send(32'h0, 5'd1, 32'h41, 5'd2, 32'h42, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd13, 1'b1, 32'h41, 32'h42);
        send(32'h0, 5'd1, 32'h51, 5'd2, 32'h52, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd14, 1'b1, 32'h51, 32'h52);
        load(32'h0, 5'd1, 32'h61, 5'd2, 32'h62, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd15, 1'b1);
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        exp_q.delete();
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_src_a", src_a, 32'd0);
        check("flush_rd_we", {31'd0, rd_we}, 32'd0);
        send(32'h0, 5'd1, 32'h71, 5'd2, 32'h72, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd16, 1'b1, 32'h71, 32'h72);
        load(32'h0, 5'd1, 32'h81, 5'd2, 32'h82, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd17, 1'b1);
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        exp_q.delete();
        check("flush_in_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();

        // use_pc / use_imm selection
        send(32'h100, 5'd1, 32'd9, 5'd2, 32'd8, 32'hFFFF_FFFC, 1'b1, 1'b1, ALU_SUB, 5'd7, 1'b1, 32'h100, 32'hFFFF_FFFC);
        tick();

        // back-to-back throughput with out_ready held high
        stalls = 0;
        for (int i = 0; i < 4; i++)
            send(32'h0, 5'd1, 32'(i), 5'd2, 32'(i + 100), 32'd0, 1'b0, 1'b0, ALU_ADD, 5'(i + 20), 1'b1, 32'(i), 32'(i + 100));
        check("thru_stalls", stalls, 32'd0);
        tick();

        // reset mid-stream discards both entries
        out_ready = 1'b0;
        send(32'h0, 5'd1, 32'h91, 5'd2, 32'h92, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd18, 1'b1, 32'h91, 32'h92);
        send(32'h0, 5'd1, 32'hA1, 5'd2, 32'hA2, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd19, 1'b1, 32'hA1, 32'hA2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU.
- Accepts decoded instructions from decode over a valid/ready handshake, resolves register-operand hazards by forwarding, and holds up to two instructions in a registered skid buffer.
- Presents src_a, src_b and alu_op to the ALU, plus destination info for writeback.
- Decouples decode from ALU/writeback stalls without a combinational ready path.

Parameters:
- XLEN, 32, operand/data width (ALU is 32-bit; only 32 supported)
- RADDR_W, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held and incoming instructions
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage can accept (registered)
- in_pc  in  XLEN  instruction PC
- in_rs1_addr, in_rs2_addr  in  RADDR_W  source register numbers
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_use_pc  in  1  src_a = pc instead of rs1
- in_use_imm  in  1  src_b = imm instead of rs2
- in_alu_op  in  alu_op_e  ALU operation
- in_rd_addr  in  RADDR_W  destination register
- in_rd_we  in  1  instruction writes rd
- fwd_ex_we, fwd_ex_rd, fwd_ex_data  in  1/RADDR_W/XLEN  result being produced this cycle by ALU stage
- fwd_wb_we, fwd_wb_rd, fwd_wb_data  in  1/RADDR_W/XLEN  result being written to register file this cycle
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  ALU/downstream accepts
- src_a, src_b  out  XLEN  ALU operands
- alu_op  out  alu_op_e  ALU operation
- rd_addr  out  RADDR_W; rd_we  out  1  destination info

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Storage: two entries, head (feeds outputs) and skid. Each holds pc, rs1/rs2 addr+data, imm, use_pc, use_imm, alu_op, rd_addr, rd_we.
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Ready and valid:
  - in_ready = !skid_valid, a registered signal.
  - out_valid = head_valid.
- Capture forwarding, applied to the incoming rs1/rs2 data at in_fire. Priority for each source:
  1. fwd_ex, if fwd_ex_we and fwd_ex_rd == addr.
  2. fwd_wb, if fwd_wb_we and fwd_wb_rd == addr.
  3. Register-file data.
  - addr == 0 is never forwarded; its data is forced to 0.
- Snoop: every held valid entry updates its rs1/rs2 data each cycle using the same priority and x0 rule. A value captured while held is never lost.
- Entry movement per cycle, evaluated in order:
  - out_fire and skid_valid: head <= skid. If in_fire is also true (impossible, since in_ready = 0), no effect.
  - out_fire and !skid_valid: head <= incoming if in_fire, else head_valid <= 0.
  - !out_fire and in_fire: fill head if empty, else fill skid.
- Ordering: strict FIFO; instructions leave in acceptance order.
- Output operands (combinational from head, after the head's snooped data):
  - src_a = use_pc ? pc : rs1_data.
  - src_b = use_imm ? imm : rs2_data.
  - When out_valid = 0: src_a = src_b = 0, alu_op = ALU_ADD, rd_addr = 0, rd_we = 0.
- Latency: 1 cycle, in_fire to out_valid, when empty. Throughput is 1 instruction/cycle with out_ready held high.
- Flush:
  - Takes effect at the next edge: head_valid = skid_valid = 0, in_ready = 1.
  - An instruction presented in the flush cycle is dropped even if in_fire.
  - Flush has priority over all movement.
- Reset (rst high at an edge):
  - head_valid = skid_valid = 0, all stored fields 0.
  - Outputs: out_valid = 0, in_ready = 1, src_a = src_b = 0, alu_op = ALU_ADD, rd_addr = 0, rd_we = 0.
  - Inputs are ignored while rst is high. Reset mid-stream discards both entries.
- Full condition: skid_valid = 1 → in_ready = 0 the next cycle. in_valid is ignored while in_ready = 0.
- Protocol rule: once out_valid = 1, the head is not withdrawn until out_fire or flush. Operand values may change only via snoop.

Test Plan:
- Reset then single issue: after rst, issue ADD rs1=x1 (data 5), rs2=x2 (data 7) with out_ready=1 → next cycle out_valid=1, src_a=5, src_b=7, alu_op=ALU_ADD; in_ready=1 throughout.
- Forward priority: capture rs1=x3 (rf data 1) with fwd_ex x3=0x10 and fwd_wb x3=0x20 both active → src_a=0x10. Repeat with rs1=x0 and fwd_ex_rd=0 → src_a=0.
- Backpressure/skid: out_ready=0, issue I1 and I2 on consecutive cycles → in_ready=0 the cycle after I2. Raise out_ready → I1 then I2 emerge in order; in_ready=1 again one cycle after I1 leaves.
- Snoop while held: hold I1 (rs2=x4, data 0) with out_ready=0; pulse fwd_wb x4=0xABCD one cycle → src_b=0xABCD and stays after the pulse; use_imm=1 case still shows imm.
- Flush mid-operation: both entries full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, no flushed or incoming instruction ever appears.
- use_pc/use_imm: pc=0x100, imm=0xFFFFFFFC, op ALU_SUB → src_a=0x100, src_b=0xFFFFFFFC.
